// File: rtl/add_accum.sv
// add_accum: packet accumulator behind an adder stage.
// Sums signed operands of a packet (wrapping), counts them (saturating) and
// tracks sticky signed overflow. At the packet's last operand it holds the
// result until downstream accepts it, stalling upstream in the meantime.
module add_accum #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    input  logic             out_ready
);

    typedef enum logic {
        ACC  = 1'b0,   // accepting operands of the current packet
        HOLD = 1'b1    // presenting the completed packet result
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [WIDTH-1:0] sum_next;
    logic             ovf_step;
    logic             in_fire;
    logic             out_fire;

    // Handshake decode and the next running sum with its overflow condition.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        sum_next = acc + in_data;
        // Overflow: both addends share a sign and the wrapped result flips it.
        ovf_step = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                   (sum_next[WIDTH-1] != acc[WIDTH-1]);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Ready/valid are pure decodes of the state register.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    // Result ports expose the working registers directly.
    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    // Packet state machine: accumulate in ACC, present in HOLD; clr wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= ACC;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (in_fire) begin
                        acc   <= sum_next;
                        count <= (count == CNT_MAX) ? count : count + CNT_ONE;
                        ovf   <= ovf | ovf_step;
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state <= ACC;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
